// File: rtl/pipe_muldiv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_defs
//   Shared definitions for the EX-stage multiply/divide sequencer:
//   operand width, mul/div op codes, sequencer state codes and small
//   op-decoding helpers.
// ---------------------------------------------------------------------------
package pipe_defs;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

  // Signed variants take magnitudes and get a sign fix at the end.
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/pipe_muldiv_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_muldiv_ctrl_if
//   EX-stage <-> mul/div unit bundle.
//   master (EX side) drives : start, op, rs_val, rt_val, rd_req, wr_hi,
//                             wr_lo, wr_data, flush
//   slave  (mul/div unit)   : hi, lo, busy, stall, done
// ---------------------------------------------------------------------------
interface pipe_muldiv_ctrl_if
  import pipe_defs::*;
#(
  parameter int WIDTH = XLEN
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             rd_req;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             flush;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;
  logic             done;

  modport master (
    output start, op, rs_val, rt_val, rd_req, wr_hi, wr_lo, wr_data, flush,
    input  hi, lo, busy, stall, done
  );

  modport slave (
    input  start, op, rs_val, rt_val, rd_req, wr_hi, wr_lo, wr_data, flush,
    output hi, lo, busy, stall, done
  );
endinterface

// File: rtl/pipe_muldiv_ctrl_iter_core.sv
// ---------------------------------------------------------------------------
// muldiv_iter_core
//   One combinational iteration on the {acc, q} pair.
//   Multiply : shift-add; q holds the multiplier, b the multiplicand.
//   Divide   : restoring step; q holds the dividend/quotient, b the divisor.
// Ports
//   is_div           select divide step (1) or multiply step (0)
//   acc, q, b        current partial state and second operand
//   acc_next, q_next state after one iteration
// ---------------------------------------------------------------------------
module muldiv_iter_core
  import pipe_defs::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next
);
  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] shl_s;
  logic           fits_s;

  // Single mul or div iteration
  always_comb begin
    sum_s  = {1'b0, acc} + {1'b0, b};
    shl_s  = {acc, q[WIDTH-1]};
    // Partial remainder stays below the divisor, so the difference fits WIDTH bits.
    fits_s = (shl_s >= {1'b0, b});
    if (is_div) begin
      if (fits_s) begin
        acc_next = shl_s[WIDTH-1:0] - b;
        q_next   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = shl_s[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (q[0]) begin
        acc_next = sum_s[WIDTH:1];
        q_next   = {sum_s[0], q[WIDTH-1:1]};
      end else begin
        acc_next = {1'b0, acc[WIDTH-1:1]};
        q_next   = {acc[0], q[WIDTH-1:1]};
      end
    end
  end
endmodule

// File: rtl/pipe_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_muldiv_ctrl
//   Iterative MULT/MULTU/DIV/DIVU sequencer for the EX stage. Owns HI/LO,
//   serves MFHI/MFLO/MTHI/MTLO and stalls the pipe on conflicting accesses.
// Ports
//   clk  rising-edge clock
//   rst  synchronous active-low reset
//   ena  global enable, 0 freezes all state
//   bus  slave side of pipe_muldiv_ctrl_if (requests in, hi/lo/busy/stall/done out)
// ---------------------------------------------------------------------------
module pipe_muldiv_ctrl
  import pipe_defs::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  pipe_muldiv_ctrl_if.slave bus
);
  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  md_state_e          state_r, state_s;
  logic [CW-1:0]      count_r;
  logic [WIDTH-1:0]   acc_r, q_r, b_r, hi_r, lo_r;
  logic               is_div_r, quo_neg_r, rem_neg_r, div0_r, busy_r, done_r;
  logic [WIDTH-1:0]   acc_nx_s, q_nx_s, abs_a_s, abs_b_s, res_hi_s, res_lo_s;
  logic [2*WIDTH-1:0] prod_s;
  logic               sa_s, sb_s;

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .is_div   (is_div_r),
    .acc      (acc_r),
    .q        (q_r),
    .b        (b_r),
    .acc_next (acc_nx_s),
    .q_next   (q_nx_s)
  );

  // Operand signs and magnitudes at issue
  always_comb begin
    sa_s    = op_is_signed(bus.op) & bus.rs_val[WIDTH-1];
    sb_s    = op_is_signed(bus.op) & bus.rt_val[WIDTH-1];
    abs_a_s = sa_s ? -bus.rs_val : bus.rs_val;
    abs_b_s = sb_s ? -bus.rt_val : bus.rt_val;
  end

  // Sign-corrected result written in FIX
  always_comb begin
    prod_s   = quo_neg_r ? -{acc_r, q_r} : {acc_r, q_r};
    res_hi_s = prod_s[2*WIDTH-1:WIDTH];
    res_lo_s = prod_s[WIDTH-1:0];
    if (is_div_r) begin
      // Remainder takes the dividend's sign; for a zero divisor this restores rs_val.
      res_hi_s = rem_neg_r ? -acc_r : acc_r;
      if (div0_r) begin
        res_lo_s = {WIDTH{1'b1}};
      end else if (quo_neg_r) begin
        res_lo_s = -q_r;
      end else begin
        res_lo_s = q_r;
      end
    end else begin
      res_hi_s = prod_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Next-state logic; flush always returns to IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      MD_IDLE: state_s = bus.start ? MD_CALC : MD_IDLE;
      MD_CALC: state_s = (count_r == CNT_LAST) ? MD_FIX : MD_CALC;
      MD_FIX:  state_s = MD_IDLE;
      default: state_s = MD_IDLE;
    endcase
    if (bus.flush) begin
      state_s = MD_IDLE;
    end else begin
      state_s = state_s;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= MD_IDLE;
    end else if (ena) begin
      state_r <= state_s;
    end
  end

  // Datapath, HI/LO and status registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r   <= {CW{1'b0}};
      acc_r     <= {WIDTH{1'b0}};
      q_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      is_div_r  <= 1'b0;
      quo_neg_r <= 1'b0;
      rem_neg_r <= 1'b0;
      div0_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else if (ena) begin
      done_r <= 1'b0;
      if (bus.flush) begin
        busy_r <= 1'b0;
      end else begin
        case (state_r)
          MD_IDLE: begin
            if (bus.wr_hi) hi_r <= bus.wr_data;
            if (bus.wr_lo) lo_r <= bus.wr_data;
            if (bus.start) begin
              acc_r     <= {WIDTH{1'b0}};
              q_r       <= abs_a_s;
              b_r       <= abs_b_s;
              is_div_r  <= op_is_div(bus.op);
              quo_neg_r <= sa_s ^ sb_s;
              rem_neg_r <= op_is_div(bus.op) & sa_s;
              div0_r    <= (bus.rt_val == {WIDTH{1'b0}});
              count_r   <= {CW{1'b0}};
              busy_r    <= 1'b1;
            end
          end
          MD_CALC: begin
            acc_r   <= acc_nx_s;
            q_r     <= q_nx_s;
            count_r <= count_r + CNT_ONE;
          end
          MD_FIX: begin
            hi_r   <= res_hi_s;
            lo_r   <= res_lo_s;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
          default: busy_r <= 1'b0;
        endcase
      end
    end
  end

  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  // Any HI/LO access or new issue must wait while an op is in flight.
  assign bus.stall = busy_r & (bus.start | bus.rd_req | bus.wr_hi | bus.wr_lo);

endmodule

// File: tb/tb_pipe_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_muldiv_ctrl
//   Self-checking bench: directed corner cases plus randomized ops compared
//   against an arithmetic reference model of MIPS HI/LO semantics.
// ---------------------------------------------------------------------------
module tb_pipe_muldiv_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic ena;

  pipe_muldiv_ctrl_if #(.WIDTH(32)) bus ();

  pipe_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference HI/LO for one op, straight from the arithmetic definition.
  task automatic ref_md(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rh, output logic [31:0] rl);
    longint          p;
    longint unsigned pu;
    int              qi, ri;
    case (o)
      2'b00: begin
        p  = longint'($signed(a)) * longint'($signed(b));
        rh = p[63:32];
        rl = p[31:0];
      end
      2'b01: begin
        pu = {32'd0, a} * {32'd0, b};
        rh = pu[63:32];
        rl = pu[31:0];
      end
      2'b10: begin
        if (b == 32'd0) begin
          rl = 32'hFFFF_FFFF; rh = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          rl = 32'h8000_0000; rh = 32'd0;
        end else begin
          qi = $signed(a) / $signed(b);
          ri = $signed(a) % $signed(b);
          rl = qi; rh = ri;
        end
      end
      default: begin
        if (b == 32'd0) begin
          rl = 32'hFFFF_FFFF; rh = a;
        end else begin
          rl = a / b; rh = a % b;
        end
      end
    endcase
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // hz: 0 none, 1 MFHI/MFLO from cycle 5, 2 start at cycle 8, 3 MTLO at cycle 10,
  //     4 ena low for 5 cycles after cycle 10, 5 MTHI together with start
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int hz);
    logic [31:0] eh, el;
    int n;
    ref_md(o, a, b, eh, el);
    bus.start = 1'b1; bus.op = o; bus.rs_val = a; bus.rt_val = b;
    if (hz == 5) begin bus.wr_hi = 1'b1; bus.wr_data = 32'hA5A5_0F0F; end
    tick();
    bus.start = 1'b0; bus.wr_hi = 1'b0;
    bus.rs_val = $urandom; bus.rt_val = $urandom;
    if (hz == 5) check_val("mthi_with_start", bus.hi, 32'hA5A5_0F0F);
    n = 0;
    while (!bus.done && n < 100) begin
      if (hz == 1 && n >= 5) begin
        bus.rd_req = 1'b1; #1;
        check_val("stall_rd", bus.stall, 1'b1);
      end
      if (hz == 2 && n == 8) begin
        bus.start = 1'b1; bus.op = 2'($urandom_range(0, 3));
        bus.rs_val = $urandom; bus.rt_val = $urandom; #1;
        check_val("stall_start", bus.stall, 1'b1);
      end
      if (hz == 3 && n == 10) begin
        bus.wr_lo = 1'b1; bus.wr_data = 32'h55; #1;
        check_val("stall_mtlo", bus.stall, 1'b1);
      end
      if (hz == 4) ena = (n >= 10 && n < 15) ? 1'b0 : 1'b1;
      tick();
      n++;
      bus.start = 1'b0; bus.wr_lo = 1'b0;
      if (hz == 3 && n == 11) check_val("mtlo_blocked", bus.lo, exp_lo);
    end
    ena = 1'b1;
    check_val("latency", n, (hz == 4) ? 38 : 33);
    check_val("hi", bus.hi, eh);
    check_val("lo", bus.lo, el);
    check_val("done_pulse", bus.done, 1'b1);
    if (hz == 1) begin
      check_val("stall_after_done", bus.stall, 1'b0);
      bus.rd_req = 1'b0;
    end
    tick();
    check_val("done_one_cycle", bus.done, 1'b0);
    check_val("idle_after_done", bus.busy, 1'b0);
    exp_hi = eh; exp_lo = el;
  endtask

  initial begin
    int dn;
    rst = 1'b0; ena = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.rs_val = 32'd0; bus.rt_val = 32'd0;
    bus.rd_req = 1'b0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wr_data = 32'd0;
    bus.flush = 1'b0;
    tick(); tick();
    check_val("rst_hi", bus.hi, 32'd0);
    check_val("rst_lo", bus.lo, 32'd0);
    check_val("rst_busy", bus.busy, 1'b0);
    check_val("rst_done", bus.done, 1'b0);
    check_val("rst_stall", bus.stall, 1'b0);
    rst = 1'b1;
    tick();

    // MTHI / MTLO while idle
    bus.wr_hi = 1'b1; bus.wr_data = 32'h1234_5678; tick();
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b1; bus.wr_data = 32'h9ABC_DEF0; tick();
    bus.wr_lo = 1'b0;
    check_val("mthi_idle", bus.hi, 32'h1234_5678);
    check_val("mtlo_idle", bus.lo, 32'h9ABC_DEF0);
    exp_hi = 32'h1234_5678; exp_lo = 32'h9ABC_DEF0;

    // Directed arithmetic corners
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0);
    check_val("mult_neg_hi", bus.hi, 32'hFFFF_FFFF);
    check_val("mult_neg_lo", bus.lo, 32'hFFFF_FFEB);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check_val("multu_max_hi", bus.hi, 32'hFFFF_FFFE);
    check_val("multu_max_lo", bus.lo, 32'h0000_0001);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    check_val("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
    check_val("div_neg_hi", bus.hi, 32'hFFFF_FFFF);
    run_op(2'b11, 32'd100, 32'd0, 0);
    check_val("divu_zero_lo", bus.lo, 32'hFFFF_FFFF);
    check_val("divu_zero_hi", bus.hi, 32'd100);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check_val("div_ovf_lo", bus.lo, 32'h8000_0000);
    check_val("div_ovf_hi", bus.hi, 32'd0);
    run_op(2'b10, 32'hFFFF_FFF0, 32'd0, 0);

    // Hazards during an op
    run_op(2'b00, 32'd12345, 32'hFFFF_0001, 1);
    run_op(2'b11, 32'hDEAD_BEEF, 32'd77, 2);
    tick();
    check_val("start_not_queued", bus.busy, 1'b0);
    run_op(2'b01, 32'h0BAD_F00D, 32'd3, 3);
    run_op(2'b10, 32'd1000, 32'hFFFF_FFFD, 5);

    // Flush mid-op
    bus.start = 1'b1; bus.op = 2'b00; bus.rs_val = 32'd123; bus.rt_val = 32'd456;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    check_val("flush_busy", bus.busy, 1'b0);
    check_val("flush_hi", bus.hi, exp_hi);
    check_val("flush_lo", bus.lo, exp_lo);
    dn = 0;
    repeat (40) begin tick(); if (bus.done) dn++; end
    check_val("flush_no_done", dn, 0);
    run_op(2'b00, 32'd6, 32'd7, 0);
    check_val("after_flush_lo", bus.lo, 32'd42);
    check_val("after_flush_hi", bus.hi, 32'd0);
    bus.start = 1'b1; bus.flush = 1'b1; tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    check_val("flush_kills_start", bus.busy, 1'b0);

    // Enable gap mid-op
    run_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0001, 4);

    // Randomized ops
    for (int i = 0; i < 30; i++) begin
      run_op(2'($urandom_range(0, 3)), rnd_opnd(), rnd_opnd(), 0);
    end

    // Reset mid-op
    bus.start = 1'b1; bus.op = 2'b11; bus.rs_val = 32'd999; bus.rt_val = 32'd5;
    tick();
    bus.start = 1'b0;
    repeat (20) tick();
    rst = 1'b0; bus.rd_req = 1'b1;
    tick();
    check_val("midrst_hi", bus.hi, 32'd0);
    check_val("midrst_lo", bus.lo, 32'd0);
    check_val("midrst_busy", bus.busy, 1'b0);
    check_val("midrst_done", bus.done, 1'b0);
    check_val("midrst_stall", bus.stall, 1'b0);
    rst = 1'b1; bus.rd_req = 1'b0;
    dn = 0;
    repeat (40) begin tick(); if (bus.done) dn++; end
    check_val("midrst_no_done", dn, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
